// File: rtl/riscv_microcode_pkg.sv
// Shared definitions for the microcode decode/sequencer slice: word geometry,
// slot field positions and the sequencer state encoding.
package riscv_microcode_pkg;

  localparam int MICROCODE_WIDTH = 64;
  localparam int SLOT_WIDTH      = 16;
  localparam int NUM_SLOTS       = MICROCODE_WIDTH / SLOT_WIDTH;
  localparam int INDEX_WIDTH     = $clog2(NUM_SLOTS);

  localparam int LAST_BIT    = 15;
  localparam int NOP_BIT     = 14;
  localparam int PAYLOAD_MSB = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RETIRE = 2'd2,
    ERROR  = 2'd3
  } seq_state_e;

  // Slot 0 lives in the most significant bits of the word.
  function automatic logic [SLOT_WIDTH-1:0] get_slot(
    input logic [MICROCODE_WIDTH-1:0] word,
    input logic [INDEX_WIDTH-1:0]     idx
  );
    logic [SLOT_WIDTH-1:0] slot;
    slot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == i[INDEX_WIDTH-1:0])
        slot = word[MICROCODE_WIDTH-1-SLOT_WIDTH*i -: SLOT_WIDTH];
    end
    return slot;
  endfunction

endpackage

// File: rtl/riscv_microcode_sequencer_uop_timeout_counter.sv
// Counts stalled micro-op cycles and flags when the execution unit has kept
// a valid micro-op waiting for TIMEOUT_CYCLES cycles.
module uop_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (count_en && !expired)
      count <= count + 1'b1;
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/riscv_microcode_sequencer.sv
// Splits a 64-bit microcode word into four 16-bit micro-ops and issues them
// in order to the execution unit over a valid/ready handshake.
module riscv_microcode_sequencer
  import riscv_microcode_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [MICROCODE_WIDTH-1:0] microcode_word,
  input  logic [31:0]                current_instruction,
  input  logic                       microcode_valid,
  output logic                       instr_ready,
  output logic [SLOT_WIDTH-1:0]      uop,
  output logic [INDEX_WIDTH-1:0]     uop_index,
  output logic                       uop_valid,
  input  logic                       uop_ready,
  output logic [31:0]                instruction_out,
  output logic                       busy,
  output logic                       done,
  output logic                       illegal,
  output logic                       error
);

  seq_state_e                 state_q, state_d;
  logic [MICROCODE_WIDTH-1:0] word_q;
  logic [31:0]                instr_q;
  logic [INDEX_WIDTH-1:0]     index_q, index_d;
  logic                       illegal_q;

  logic [SLOT_WIDTH-1:0] slot;
  logic                  slot_is_nop;
  logic                  slot_is_final;
  logic                  accept;
  logic                  reject;
  logic                  advance;
  logic                  expired;

  assign slot          = get_slot(word_q, index_q);
  assign slot_is_nop   = slot[NOP_BIT];
  assign slot_is_final = slot[LAST_BIT] || (index_q == INDEX_WIDTH'(NUM_SLOTS - 1));

  assign accept = (state_q == IDLE) && microcode_valid && (|microcode_word);
  assign reject = (state_q == IDLE) && microcode_valid && !(|microcode_word);

  // A NOP slot advances on its own; a real slot advances only on handshake.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    uop_valid = 1'b0;
    advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          index_d = '0;
        end
      end
      ISSUE: begin
        if (expired) begin
          state_d = ERROR;
        end else if (slot_is_nop) begin
          advance = 1'b1;
        end else begin
          uop_valid = 1'b1;
          advance   = uop_ready;
        end
        if (advance) begin
          if (slot_is_final)
            state_d = RETIRE;
          else
            index_d = index_q + 1'b1;
        end
      end
      RETIRE:  state_d = IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      index_q   <= '0;
      word_q    <= '0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      illegal_q <= reject;
      if (accept) begin
        word_q  <= microcode_word;
        instr_q <= current_instruction;
      end
    end
  end

  uop_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .count_en(uop_valid && !uop_ready),
    .clear   (advance || (state_q != ISSUE)),
    .expired (expired)
  );

  assign instr_ready     = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == RETIRE);
  assign error           = (state_q == ERROR);
  assign illegal         = illegal_q;
  assign uop             = slot;
  assign uop_index       = index_q;
  assign instruction_out = instr_q;

endmodule

// File: tb/tb_riscv_microcode_sequencer.sv
// Self-checking bench: directed and random microcode words checked against a
// slot-by-slot model of the expected issue sequence.
module tb_riscv_microcode_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] microcode_word;
  logic [31:0] current_instruction;
  logic        microcode_valid;
  logic        instr_ready;
  logic [15:0] uop;
  logic [1:0]  uop_index;
  logic        uop_valid;
  logic        uop_ready;
  logic [31:0] instruction_out;
  logic        busy;
  logic        done;
  logic        illegal;
  logic        error;

  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  riscv_microcode_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .microcode_word     (microcode_word),
    .current_instruction(current_instruction),
    .microcode_valid    (microcode_valid),
    .instr_ready        (instr_ready),
    .uop                (uop),
    .uop_index          (uop_index),
    .uop_valid          (uop_valid),
    .uop_ready          (uop_ready),
    .instruction_out    (instruction_out),
    .busy               (busy),
    .done               (done),
    .illegal            (illegal),
    .error              (error)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [15:0] slotOf(input logic [63:0] w, input int s);
    return 16'((w >> (16 * (3 - s))) & 64'hFFFF);
  endfunction

  task automatic driveNoise(input bit noise);
    if (noise) begin
      microcode_valid = 1'($urandom_range(1));
      microcode_word  = {$urandom, $urandom};
    end
  endtask

  // Entered and left at a negedge with the sequencer idle.
  task automatic applyStimulus(input logic [63:0] word, input logic [31:0] instr,
                               input int stallPct, input int stallLimit, input bit noise);
    checkOutput("idle_ready", instr_ready, 1);
    checkOutput("idle_busy", busy, 0);
    microcode_valid     = 1'b1;
    microcode_word      = word;
    current_instruction = instr;
    @(negedge clk);
    microcode_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      logic [15:0] sl;
      sl = slotOf(word, s);
      if (sl[14]) begin
        checkOutput("nop_valid", uop_valid, 0);
        checkOutput("nop_busy", busy, 1);
        if (noise) uop_ready = 1'($urandom_range(1));
        driveNoise(noise);
        @(negedge clk);
        uop_ready = 1'b0;
      end else begin
        int stalls;
        bit accepted;
        stalls   = 0;
        accepted = 1'b0;
        while (!accepted) begin
          checkOutput("uop_valid", uop_valid, 1);
          checkOutput("uop", uop, sl);
          checkOutput("uop_index", uop_index, s);
          checkOutput("instr_out", instruction_out, instr);
          checkOutput("done_early", done, 0);
          accepted = (stalls >= stallLimit) || (int'($urandom_range(99)) >= stallPct);
          if (!accepted) stalls++;
          uop_ready = accepted;
          driveNoise(noise);
          @(negedge clk);
        end
        uop_ready = 1'b0;
      end
      if (sl[15]) break;
    end
    checkOutput("done", done, 1);
    checkOutput("retire_ready", instr_ready, 0);
    checkOutput("retire_valid", uop_valid, 0);
    microcode_valid = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", done, 0);
    checkOutput("ready_again", instr_ready, 1);
  endtask

  initial begin
    int validCycles;
    logic [63:0] w;

    reset               = 1'b1;
    microcode_word      = '0;
    current_instruction = '0;
    microcode_valid     = 1'b0;
    uop_ready           = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", instr_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", uop_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_uop", uop, 0);
    checkOutput("rst_index", uop_index, 0);
    checkOutput("rst_instr", instruction_out, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed words");
    applyStimulus(64'h0001_0002_0003_8004, 32'h0000_0013, 0, 0, 0);
    applyStimulus(64'h8123_FFFF_FFFF_FFFF, 32'h1234_5678, 0, 0, 0);
    applyStimulus(64'h4000_0005_8006_0000, 32'hCAFE_0001, 0, 0, 0);
    applyStimulus(64'h0001_8002_0000_0000, 32'hCAFE_0002, 100, 3, 0);
    applyStimulus(64'h4000_4000_4000_4000, 32'hCAFE_0003, 0, 0, 0);

    $display("[TB] illegal word");
    microcode_valid = 1'b1;
    microcode_word  = '0;
    @(negedge clk);
    microcode_valid = 1'b0;
    checkOutput("illegal_pulse", illegal, 1);
    checkOutput("illegal_busy", busy, 0);
    checkOutput("illegal_valid", uop_valid, 0);
    @(negedge clk);
    checkOutput("illegal_clear", illegal, 0);
    checkOutput("illegal_idle", instr_ready, 1);

    $display("[TB] random words");
    for (int n = 0; n < 40; n++) begin
      w = {$urandom, $urandom};
      for (int s = 0; s < 4; s++) begin
        if ($urandom_range(3) == 0) w[63 - 16*s] = 1'b1;
        else w[63 - 16*s] = 1'b0;
        if ($urandom_range(4) == 0) w[62 - 16*s] = 1'b1;
        else w[62 - 16*s] = 1'b0;
      end
      if (w == 64'd0) w = 64'd1;
      applyStimulus(w, $urandom, 30, 8, 1);
    end

    $display("[TB] timeout");
    microcode_valid     = 1'b1;
    microcode_word      = 64'h0001_8002_0000_0000;
    current_instruction = 32'h0BAD_0001;
    uop_ready           = 1'b0;
    @(negedge clk);
    microcode_valid = 1'b0;
    validCycles     = 0;
    while (uop_valid === 1'b1 && validCycles < 400) begin
      validCycles++;
      @(negedge clk);
    end
    checkOutput("timeout_len", validCycles, 255);
    @(negedge clk);
    checkOutput("err_flag", error, 1);
    checkOutput("err_valid", uop_valid, 0);
    checkOutput("err_ready", instr_ready, 0);
    checkOutput("err_busy", busy, 1);
    microcode_valid = 1'b1;
    microcode_word  = 64'h8001_0000_0000_0000;
    uop_ready       = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("err_sticky", error, 1);
    checkOutput("err_no_done", done, 0);
    microcode_valid = 1'b0;
    uop_ready       = 1'b0;
    reset           = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("err_cleared", error, 0);
    checkOutput("err_rst_ready", instr_ready, 1);

    $display("[TB] reset mid-issue");
    microcode_valid     = 1'b1;
    microcode_word      = 64'h0001_0002_8003_0000;
    current_instruction = 32'hDEAD_BEEF;
    @(negedge clk);
    microcode_valid = 1'b0;
    checkOutput("mid_valid_pre", uop_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_valid", uop_valid, 0);
    checkOutput("mid_ready", instr_ready, 1);
    checkOutput("mid_done", done, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_instr", instruction_out, 0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("mid_no_done", done, 0);
      checkOutput("mid_idle_valid", uop_valid, 0);
      @(negedge clk);
    end
    applyStimulus(64'h0001_0002_0003_8004, 32'h0000_0033, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
